// File: rtl/concat_sequencer_pkg.sv
// Shared types and field widths for the beat-to-word sequencer.
// Imported by the sequencer and its packing sub-module.
package concat_sequencer_pkg;

  localparam int A_W    = 8;
  localparam int B_W    = 8;
  localparam int C_W    = 8;
  localparam int D_W    = 4;
  localparam int E_W    = 4;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    GET_C,
    GET_DE,
    OUT
  } state_t;

endpackage

// File: rtl/concat_sequencer_concatenate.sv
// Packs the five field registers into one output word.
// Pure wiring; A lands in the most significant byte.
module concat_sequencer_concatenate
  import concat_sequencer_pkg::*;
(
  input  logic [A_W-1:0]    a,
  input  logic [B_W-1:0]    b,
  input  logic [C_W-1:0]    c,
  input  logic [D_W-1:0]    d,
  input  logic [E_W-1:0]    e,
  output logic [WORD_W-1:0] word
);

  assign word = {a, b, c, d, e};

endmodule

// File: rtl/concat_sequencer.sv
// Collects A, B, C and a D/E nibble pair into a 32-bit word,
// with restart on a new start beat and an inter-beat timeout.
module concat_sequencer
  import concat_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_abort,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t state;
  state_t state_nxt;

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [C_W-1:0] c_q;
  logic [D_W-1:0] d_q;
  logic [E_W-1:0] e_q;

  logic [15:0] idle_cnt;
  logic [15:0] word_cnt;
  logic        err_q;

  logic accept;
  logic xfer;
  logic in_get;
  logic timeout;
  logic abort;

  assign accept  = in_valid & in_ready;
  assign xfer    = out_valid & out_ready;
  assign in_get  = (state == GET_B) | (state == GET_C)
                 | (state == GET_DE);
  assign timeout = in_get & ~accept & (idle_cnt == TMO);

  // stray beat in IDLE, restart mid-word, or timeout
  assign abort = (accept & (state == IDLE) & ~in_sof)
               | (accept & in_get & in_sof)
               | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && in_sof) state_nxt = GET_B;
      end
      GET_B: begin
        if (accept)       state_nxt = in_sof ? GET_B : GET_C;
        else if (timeout) state_nxt = IDLE;
      end
      GET_C: begin
        if (accept)       state_nxt = in_sof ? GET_B : GET_DE;
        else if (timeout) state_nxt = IDLE;
      end
      GET_DE: begin
        if (accept)       state_nxt = in_sof ? GET_B : OUT;
        else if (timeout) state_nxt = IDLE;
      end
      OUT: begin
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != OUT);
    busy      = (state != IDLE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
    end else if (accept) begin
      unique case (1'b1)
        in_sof:                      a_q <= in_data;
        (!in_sof && state == GET_B): b_q <= in_data;
        (!in_sof && state == GET_C): c_q <= in_data;
        (!in_sof && state == GET_DE): begin
          d_q <= in_data[7:4];
          e_q <= in_data[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idle_cnt <= '0;
    else if (accept || !in_get || timeout) idle_cnt <= '0;
    else                                idle_cnt <= idle_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    word_cnt <= '0;
    else if (xfer) word_cnt <= word_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= abort;
  end

  // fields only change while accepting, so the word is steady in OUT
  concat_sequencer_concatenate u_concat (
    .a    (a_q),
    .b    (b_q),
    .c    (c_q),
    .d    (d_q),
    .e    (e_q),
    .word (out_word)
  );

  assign err_abort  = err_q;
  assign word_count = word_cnt;

endmodule

// File: tb/tb_concat_sequencer.sv
// Scoreboard bench: beat-level reference model feeds a word queue,
// a negedge monitor pops and compares every delivered word.
module tb_concat_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_abort;
  logic        busy;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  concat_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_abort  (err_abort),
    .busy       (busy),
    .word_count (word_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          exp_err = 0;
  int          obs_err = 0;
  logic [15:0] exp_cnt = '0;

  int         pos = 0;
  int         idle_run = 0;
  logic [7:0] fa, fb, fc;

  bit rand_ready  = 1'b0;
  bit fixed_ready = 1'b1;
  bit mon_en      = 1'b0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference model at beat granularity
  function automatic void m_idle(int n);
    idle_run += n;
    if (pos != 0 && idle_run > T) begin
      exp_err++;
      pos = 0;
    end
  endfunction

  function automatic void m_beat(logic [7:0] d, bit sof);
    idle_run = 0;
    if (sof) begin
      if (pos != 0) exp_err++;
      fa  = d;
      pos = 1;
    end else begin
      case (pos)
        0: exp_err++;
        1: begin fb = d; pos = 2; end
        2: begin fc = d; pos = 3; end
        default: begin
          exp_q.push_back({fa, fb, fc, d});
          pos = 0;
        end
      endcase
    end
  endfunction

  task automatic send(logic [7:0] d, bit sof, int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    m_idle(gap);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    w = 0;
    while (!in_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_wait: got stalled want ready");
    end
    @(posedge clk); #1;
    m_beat(d, sof);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    m_idle(n);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      out_ready = rand_ready ? 1'($urandom % 2) : fixed_ready;
    end
  end

  // monitor: scoreboard pop, hold stability, error pulse count
  logic        pend = 1'b0;
  logic [31:0] pend_word;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      pend = 1'b0;
    end else begin
      if (err_abort) obs_err++;
      if (pend)
        check("hold", {out_valid, out_word}, {1'b1, pend_word});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %h want none", out_word);
        end else begin
          check("word", out_word, exp_q.pop_front());
        end
        check("word_count", word_count, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
      end
      pend      = out_valid && !out_ready;
      pend_word = out_word;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", out_word, 0);
    check("rst_ctl", {out_valid, err_abort, busy, in_ready},
          4'b0001);
    check("rst_count", word_count, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // single word, consumer always ready
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    send(8'hFF, 1, 0);
    send(8'hAA, 0, 0);
    send(8'h55, 0, 0);
    send(8'h0F, 0, 0);
    check("latency", {out_valid, out_word}, {1'b1, 32'hFFAA550F});
    @(posedge clk); #1;
    check("one_cycle", out_valid, 0);
    check("count1", word_count, 1);

    // stalled consumer for 10 cycles
    fixed_ready = 1'b0;
    send(8'hFF, 1, 0);
    send(8'hAA, 0, 0);
    send(8'h55, 0, 0);
    send(8'h0F, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("stall", {in_ready, out_valid, out_word},
            {2'b01, 32'hFFAA550F});
      @(posedge clk); #1;
    end
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_done", {out_valid, word_count}, {1'b0, 16'd2});

    // restart mid-word
    send(8'h12, 1, 0);
    send(8'h34, 0, 0);
    send(8'hAB, 1, 0);
    send(8'hCD, 0, 0);
    send(8'hEF, 0, 0);
    send(8'h01, 0, 0);
    drain();
    check("restart_err", obs_err, exp_err);

    // stray beat in IDLE
    send(8'h77, 0, 0);
    idle(2);
    check("stray_busy", busy, 0);
    check("stray_err", obs_err, exp_err);

    // timeout after T idle cycles
    send(8'h11, 1, 0);
    idle(T + 2);
    check("tmo_busy", busy, 0);
    check("tmo_err", obs_err, exp_err);

    // a beat arriving after exactly T idle cycles still counts
    send(8'h21, 1, 0);
    send(8'h22, 0, T);
    send(8'h23, 0, 0);
    send(8'h24, 0, 0);
    drain();
    check("edge_err", obs_err, exp_err);

    // reset while in GET_C
    send(8'h12, 1, 0);
    send(8'h34, 0, 0);
    rst_n = 1'b0;
    #1;
    pos = 0;
    idle_run = 0;
    exp_cnt = '0;
    check("mid_rst_word", out_word, 0);
    check("mid_rst_ctl", {out_valid, err_abort, busy, in_ready},
          4'b0001);
    check("mid_rst_count", word_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit sof;
      int gap;
      sof = (pos == 0) ? ($urandom % 10 != 0) : ($urandom % 12 == 0);
      gap = ($urandom % 8 == 0) ? $urandom_range(3, 6)
                                : $urandom_range(0, 2);
      send(8'($urandom), sof, gap);
    end
    drain();
    check("rand_err", obs_err, exp_err);

    // word counter wrap
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    force dut.word_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.word_cnt;
    exp_cnt = 16'hFFFE;
    check("preload", word_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      send(8'hC0 + 8'(k), 1, 0);
      send(8'h5A, 0, 0);
      send(8'hA5, 0, 0);
      send(8'h3C, 0, 0);
      drain();
    end
    check("wrap", word_count, 0);
    check("final_err", obs_err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/concat_sequencer.md
CONCAT_SEQUENCER -- requirements
Module: concat_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of idle cycles allowed between beats of one word (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 8 bits: the input field byte.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_sof, input, 1 bit: marks the current beat as field A (start of word).
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port out_word, output, 32 bits: the assembled word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_word is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_word.
REQ-011 SHALL have port err_abort, output, 1 bit: one-cycle pulse when a partial word is discarded or a stray beat is dropped.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port word_count, output, 16 bits: number of words delivered.

Function
REQ-014 An input beat SHALL be accepted only when in_valid=1 and in_ready=1; an output transfer SHALL occur only when out_valid=1 and out_ready=1.
REQ-015 The FSM SHALL have states IDLE, GET_B, GET_C, GET_DE and OUT.
REQ-016 in_ready SHALL be 1 in IDLE, GET_B, GET_C and GET_DE, and 0 in OUT.
REQ-017 IDLE: an accepted beat with in_sof=1 SHALL be stored as A and move the FSM to GET_B.
REQ-018 IDLE: an accepted beat with in_sof=0 SHALL be dropped, pulse err_abort, and keep the FSM in IDLE.
REQ-019 GET_B and GET_C: an accepted beat with in_sof=0 SHALL be stored as B or C respectively and advance the FSM to the next state.
REQ-020 GET_DE: an accepted beat with in_sof=0 SHALL store D=in_data[7:4] and E=in_data[3:0] and move the FSM to OUT.
REQ-021 GET_B, GET_C, GET_DE: an accepted beat with in_sof=1 SHALL pulse err_abort, store the beat as the new A, and go to GET_B (restart).
REQ-022 out_word SHALL be {A,B,C,D,E}, with A in [31:24], B in [23:16], C in [15:8], D in [7:4] and E in [3:0].
REQ-023 out_valid SHALL assert in the cycle after the GET_DE beat is accepted (latency of 1 cycle).
REQ-024 out_valid and out_word SHALL be held stable until an output transfer occurs.
REQ-025 OUT: an output transfer SHALL increment word_count (wrapping from 0xFFFF to 0x0000) and return the FSM to IDLE, with in_ready=1 in the following cycle.
REQ-026 A 16-bit idle counter SHALL clear on every accepted beat and on entry to GET_B.
REQ-027 The idle counter SHALL increment on each cycle spent in GET_B, GET_C or GET_DE without an accepted beat.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE and pulse err_abort in the same cycle, with the partial fields discarded.
REQ-029 OUT SHALL have no timeout; a stalled out_ready SHALL hold the FSM in OUT indefinitely.
REQ-030 If a timeout and an accepted beat coincide, the accepted beat SHALL take priority.
REQ-031 err_abort SHALL be high for exactly one cycle per event.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously force: FSM=IDLE, A/B/C/D/E=0, out_word=0, out_valid=0, err_abort=0, busy=0, word_count=0, idle counter=0, and in_ready=1 after reset.
REQ-033 A reset during any partial word or in OUT SHALL discard all held data, without an err_abort pulse.
REQ-034 Deassertion of rst_n SHALL take effect on the next rising edge of clk.

Structure
REQ-035 A shared package SHALL hold the FSM state enumeration and the field width constants (8, 8, 8, 4, 4 and 32).
REQ-036 The field packing SHALL be done by instantiating the existing CONCATENATE sub-module, driven from the field registers A/B/C/D/E.
REQ-037 out_word SHALL be registered; the FSM and counters SHALL be in concat_sequencer.

Verification
REQ-038 Beats FF(sof), AA, 55, 0F with out_ready=1 -> out_word=FFAA550F with out_valid for 1 cycle, 1 cycle after the 4th beat; word_count=1.
REQ-039 Same word with out_ready=0 for 10 cycles -> out_valid and out_word held, in_ready=0 throughout; the transfer occurs on the 11th cycle.
REQ-040 Beats 12(sof), 34, then AB(sof), CD, EF, 01 -> one err_abort pulse, then out_word=ABCDEF01.
REQ-041 Beat 77 without sof in IDLE -> err_abort pulse, FSM stays IDLE, no word produced; TIMEOUT_CYCLES=4, beat 11(sof), then 4 idle cycles -> err_abort, busy=0.
REQ-042 rst_n asserted low in GET_C -> all outputs 0 and in_ready=1; 0xFFFF words delivered then 1 more -> word_count wraps to 0.
